// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the ROM two-phase request/ready handshake,
// buffers fetched words with their PCs in a prefetch FIFO, and hands them to
// decode over valid/ready. Branch redirects flush the FIFO and retarget fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ROM_WAIT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] romAddrOut,
  output logic        romTriggerOut,
  input  logic        romReadyIn,
  input  logic [31:0] romDataIn,
  input  logic        branchIn,
  input  logic [31:0] branchTargetIn,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        instrValidOut,
  input  logic        instrReadyIn
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(ROM_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WAIT_C  = WW'(ROM_WAIT);

  typedef enum logic [1:0] {STARTUP, IDLE, BUSY} state_t;

  state_t        state;
  logic [WW-1:0] waitcnt;
  logic [31:0]   pc;
  logic          discard;
  logic          rdy_meta;
  logic          rdy_sync;

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic [31:0]   target;
  logic          wait_done;
  logic          capture;
  logic          issue;
  logic          push;
  logic          pop;

  assign target        = branchTargetIn & 32'hFFFF_FFFC;
  // Counter is loaded with ROM_WAIT at issue; the sample lands ROM_WAIT
  // cycles after the toggle, so the value 1 already counts as expired.
  assign wait_done     = (waitcnt <= WW'(1));
  assign capture       = (state == BUSY) && wait_done && rdy_sync;
  assign issue         = (state == IDLE) && (count < DEPTH_C) && !branchIn;
  assign push          = capture && !discard && !branchIn;
  assign instrValidOut = (count != '0);
  assign pop           = instrValidOut && instrReadyIn;
  assign instrOut      = fifo_instr[rptr];
  assign pcOut         = fifo_pc[rptr];

  // Two-flop synchroniser for the asynchronous ROM ready level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= romReadyIn;
      rdy_sync <= rdy_meta;
    end
  end

  // Fetch FSM: startup settle, request issue, wait/capture; plus PC and discard tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STARTUP;
      waitcnt       <= WAIT_C;
      romTriggerOut <= 1'b0;
      romAddrOut    <= {2'b00, RESET_VECTOR[31:2]};
      pc            <= RESET_VECTOR;
      discard       <= 1'b0;
    end else begin
      case (state)
        STARTUP: begin
          if (wait_done) begin
            state   <= IDLE;
            waitcnt <= '0;
          end else begin
            waitcnt <= waitcnt - WW'(1);
          end
        end
        IDLE: begin
          if (issue) begin
            romAddrOut    <= {2'b00, pc[31:2]};
            romTriggerOut <= ~romTriggerOut;
            waitcnt       <= WAIT_C;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (capture) begin
            state <= IDLE;
          end else if (waitcnt != '0) begin
            waitcnt <= waitcnt - WW'(1);
          end
        end
        default: state <= STARTUP;
      endcase

      // A branch landing on the capture edge drops that word directly, so
      // discard is only armed for an access that is still outstanding.
      if (capture) begin
        discard <= 1'b0;
      end
      if (branchIn && (state == BUSY) && !capture) begin
        discard <= 1'b1;
      end

      if (branchIn) begin
        pc <= target;
      end else if (push) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Prefetch FIFO: push on kept captures, pop on decode handshake, flush on branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (branchIn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_instr[wptr] <= romDataIn;
        fifo_pc[wptr]    <= pc;
        wptr             <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {pc, instr} pairs,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] romAddrOut;
  logic        romTriggerOut;
  logic        romReadyIn;
  logic [31:0] romDataIn;
  logic        branchIn;
  logic [31:0] branchTargetIn;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic        instrValidOut;
  logic        instrReadyIn;

  fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .FIFO_DEPTH(4),
    .ROM_WAIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .romAddrOut(romAddrOut),
    .romTriggerOut(romTriggerOut),
    .romReadyIn(romReadyIn),
    .romDataIn(romDataIn),
    .branchIn(branchIn),
    .branchTargetIn(branchTargetIn),
    .instrOut(instrOut),
    .pcOut(pcOut),
    .instrValidOut(instrValidOut),
    .instrReadyIn(instrReadyIn)
  );

  always #5 clk = ~clk;

  // ROM model: data follows the held address; ready is driven by the stimulus.
  logic [31:0] rom_mem [64];
  assign romDataIn = rom_mem[romAddrOut[5:0]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   cyc = 0;
  int   pop_cyc[$];
  int   toggles = 0;
  logic trig_prev = 1'b0;

  function automatic ent_t mk(input logic [31:0] p, input logic [31:0] d);
    ent_t e;
    e.pc = p;
    e.instr = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Count trigger transitions (each one is a ROM request).
  always @(negedge clk) begin
    if (rst !== 1'b0) toggles = 0;
    else if (romTriggerOut !== trig_prev) toggles++;
    trig_prev = romTriggerOut;
  end

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && instrValidOut === 1'b1 && instrReadyIn === 1'b1) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc %h instr %h, expected no output", pcOut, instrOut);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pc", pcOut, mon_e.pc);
        check("out_instr", instrOut, mon_e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branchIn = 1'b0;
    branchTargetIn = '0;
    instrReadyIn = 1'b0;
    exp_q.delete();
    pop_cyc.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_pops(input int n, input string name);
    int target;
    int budget;
    target = pops + n;
    budget = 200;
    while (pops < target && budget > 0) begin
      tick();
      budget--;
    end
    if (pops < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", name, pops, target);
    end
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    int budget;
    budget = 200;
    while (romAddrOut !== a && budget > 0) begin
      tick();
      budget--;
    end
    if (romAddrOut !== a) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: romAddrOut got %h, expected %h", name, romAddrOut, a);
    end
  endtask

  task automatic wait_trig_high(input string name);
    int budget;
    budget = 200;
    while (romTriggerOut !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    if (romTriggerOut !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: romTriggerOut got %b, expected 1", name, romTriggerOut);
    end
  endtask

  initial begin
    int bad_addr;
    int bad_valid;
    int bad_trig;
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'h1000_0000 + i;
    rom_mem[0] = 32'h11;
    rom_mem[1] = 32'h22;
    rom_mem[2] = 32'h33;
    rom_mem[3] = 32'h44;
    romReadyIn = 1'b1;

    // Reset values, then streaming fetch with decode always ready.
    rst = 1'b1;
    branchIn = 1'b0;
    branchTargetIn = '0;
    instrReadyIn = 1'b0;
    tick();
    check("rst_trigger", {31'd0, romTriggerOut}, 32'd0);
    check("rst_addr", romAddrOut, 32'd0);
    check("rst_valid", {31'd0, instrValidOut}, 32'd0);
    check("rst_instr", instrOut, 32'd0);
    check("rst_pc", pcOut, 32'd0);
    do_reset();
    instrReadyIn = 1'b1;
    exp_q.push_back(mk(32'h0, 32'h11));
    exp_q.push_back(mk(32'h4, 32'h22));
    exp_q.push_back(mk(32'h8, 32'h33));
    exp_q.push_back(mk(32'hC, 32'h44));
    wait_pops(4, "stream");
    instrReadyIn = 1'b0;
    if (pop_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        check("stream_interval", pop_cyc[i] - pop_cyc[i-1], 32'd4);
    end
    check("stream_drain", exp_q.size(), 32'd0);

    // Decode stalled: FIFO fills with exactly four requests, then resumes at 0x10.
    do_reset();
    repeat (40) tick();
    check("stall_toggles", toggles, 32'd4);
    check("stall_valid", {31'd0, instrValidOut}, 32'd1);
    check("stall_head_pc", pcOut, 32'd0);
    check("stall_head_instr", instrOut, 32'h11);
    repeat (10) tick();
    check("stall_toggles_hold", toggles, 32'd4);
    exp_q.push_back(mk(32'h0, 32'h11));
    exp_q.push_back(mk(32'h4, 32'h22));
    exp_q.push_back(mk(32'h8, 32'h33));
    exp_q.push_back(mk(32'hC, 32'h44));
    exp_q.push_back(mk(32'h10, rom_mem[4]));
    exp_q.push_back(mk(32'h14, rom_mem[5]));
    instrReadyIn = 1'b1;
    wait_pops(6, "resume");
    instrReadyIn = 1'b0;
    check("resume_drain", exp_q.size(), 32'd0);

    // Branch to 0x43 while the access for pc 0x8 is in flight.
    do_reset();
    wait_addr(32'h2, "busy_pc8");
    branchIn = 1'b1;
    branchTargetIn = 32'h43;
    tick();
    branchIn = 1'b0;
    check("br_busy_flush_valid", {31'd0, instrValidOut}, 32'd0);
    check("br_busy_addr_held", romAddrOut, 32'h2);
    exp_q.push_back(mk(32'h40, rom_mem[16]));
    exp_q.push_back(mk(32'h44, rom_mem[17]));
    instrReadyIn = 1'b1;
    wait_pops(2, "br_busy");
    instrReadyIn = 1'b0;
    check("br_busy_drain", exp_q.size(), 32'd0);

    // Branch on the same edge as a capture (pc 0x4) and a pop (pc 0x0).
    do_reset();
    wait_addr(32'h1, "busy_pc4");
    tick();
    tick();
    exp_q.push_back(mk(32'h0, 32'h11));
    branchIn = 1'b1;
    branchTargetIn = 32'h80;
    instrReadyIn = 1'b1;
    tick();
    branchIn = 1'b0;
    check("br_cap_count", {31'd0, instrValidOut}, 32'd0);
    exp_q.push_back(mk(32'h80, rom_mem[32]));
    exp_q.push_back(mk(32'h84, rom_mem[33]));
    wait_pops(2, "br_cap");
    instrReadyIn = 1'b0;
    check("br_cap_drain", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of an access.
    do_reset();
    wait_trig_high("rst_busy");
    rst = 1'b1;
    #1;
    check("arst_trigger", {31'd0, romTriggerOut}, 32'd0);
    check("arst_addr", romAddrOut, 32'd0);
    check("arst_valid", {31'd0, instrValidOut}, 32'd0);
    bad_valid = 0;
    repeat (6) begin
      tick();
      if (instrValidOut !== 1'b0) bad_valid++;
    end
    check("arst_no_capture", bad_valid, 32'd0);
    rst = 1'b0;
    exp_q.push_back(mk(32'h0, 32'h11));
    exp_q.push_back(mk(32'h4, 32'h22));
    instrReadyIn = 1'b1;
    wait_pops(2, "arst");
    instrReadyIn = 1'b0;
    check("arst_drain", exp_q.size(), 32'd0);

    // ROM not ready through and beyond the wait window.
    romReadyIn = 1'b0;
    do_reset();
    instrReadyIn = 1'b1;
    wait_trig_high("slow_rom");
    bad_addr = 0;
    bad_valid = 0;
    bad_trig = 0;
    repeat (10) begin
      tick();
      if (romAddrOut !== 32'h0) bad_addr++;
      if (instrValidOut !== 1'b0) bad_valid++;
      if (romTriggerOut !== 1'b1) bad_trig++;
    end
    check("slow_addr_stable", bad_addr, 32'd0);
    check("slow_no_capture", bad_valid, 32'd0);
    check("slow_trigger_stable", bad_trig, 32'd0);
    exp_q.push_back(mk(32'h0, 32'h11));
    exp_q.push_back(mk(32'h4, 32'h22));
    romReadyIn = 1'b1;
    wait_pops(2, "slow");
    instrReadyIn = 1'b0;
    check("slow_drain", exp_q.size(), 32'd0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
